// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter states and FSM state codes.
package branch_predictor_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;
  localparam logic [1:0] CTR_INIT  = CTR_WNT;

endpackage

// File: rtl/bp_sat_ctr2.sv
// 2-bit saturating up/down counter step: taken counts up to 11, not-taken down to 00.
module bp_sat_ctr2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_next_o
);

  always_comb begin
    ctr_next_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_next_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_next_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational lookup, one shared write port
// used by the init sweep (priority) and resolved-branch training.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int COUNT_W = 16
) (
  input  logic               stage_clk,
  input  logic               reset,
  input  logic               stage_ena,
  input  logic               clear,
  input  logic [31:0]        pc_lookup,
  output logic               branch_prediction,
  output logic [31:0]        pc_target_prediction,
  input  logic               upd_valid,
  input  logic [31:0]        upd_pc,
  input  logic               upd_taken,
  input  logic [31:0]        upd_target,
  input  logic               upd_mispredict,
  output logic               ready,
  output logic [COUNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

  // Table storage: no reset so it can map onto RAM; the sweep initialises it.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  bp_state_e          state_q;
  logic [IDX_W-1:0]   sweep_q;
  logic [COUNT_W-1:0] count_q;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, commit;
  logic [1:0]       up_ctr_d;

  logic             we_d;
  logic [IDX_W-1:0] w_idx_d;
  logic             w_valid_d;
  logic [TAG_W-1:0] w_tag_d;
  logic [31:0]      w_target_d;
  logic [1:0]       w_ctr_d;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_lookup[1:0], upd_pc[1:0]};

  assign ready = (state_q == ST_RUN);

  assign lk_idx = pc_lookup[IDX_W+1:2];
  assign lk_tag = pc_lookup[31:IDX_W+2];
  assign lk_hit = ready & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);

  assign branch_prediction    = lk_hit & ctr_q[lk_idx][1];
  assign pc_target_prediction = branch_prediction ? target_q[lk_idx] : pc_lookup + 32'd4;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
  assign commit = upd_valid & stage_ena & ready;

  bp_sat_ctr2 u_sat_ctr (
    .ctr_i      (ctr_q[up_idx]),
    .taken_i    (upd_taken),
    .ctr_next_o (up_ctr_d)
  );

  always_comb begin
    we_d       = 1'b0;
    w_idx_d    = up_idx;
    w_valid_d  = 1'b1;
    w_tag_d    = up_tag;
    w_target_d = upd_target;
    w_ctr_d    = CTR_ALLOC;
    if (state_q == ST_INIT) begin
      we_d      = 1'b1;
      w_idx_d   = sweep_q;
      w_valid_d = 1'b0;
      w_ctr_d   = CTR_INIT;
    end else if (commit && up_hit) begin
      we_d       = 1'b1;
      w_ctr_d    = up_ctr_d;
      w_target_d = upd_taken ? upd_target : target_q[up_idx];
    end else if (commit && upd_taken) begin
      we_d = 1'b1;
    end
  end

  always_ff @(posedge stage_clk) begin
    if (we_d) begin
      valid_q[w_idx_d]  <= w_valid_d;
      tag_q[w_idx_d]    <= w_tag_d;
      target_q[w_idx_d] <= w_target_d;
      ctr_q[w_idx_d]    <= w_ctr_d;
    end
  end

  // Control FSM: sweep every index once, then predict/train until clear or reset.
  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_q <= sweep_q + IDX_ONE;
          if (sweep_q == IDX_LAST) state_q <= ST_RUN;
        end
        default: begin
          if (commit && upd_mispredict && !(&count_q)) count_q <= count_q + COUNT_W'(1);
        end
      endcase
    end
  end

  assign mispredict_count = count_q;

endmodule
